array_stream_arbiter: RTL and testbench

- Shares the single write port of the 16-lane array stream datapath (DDS link feeding the serializer) between N requesters.
- Grants whole bursts of BURST words, one word per array lane, using round-robin priority.
- Throttles writes on master_full.
- After each burst, waits until the serializer has emitted BURST valid words, then signals completion and starts the next grant.
- Sits between SoC-side producers and the stream top (we/datain/valid/master_full/master_empty).

---
 rtl/array_stream_arbiter_pkg.sv | 19 +
 rtl/array_stream_arbiter_if.sv | 29 ++
 rtl/array_stream_arbiter_rr_arbiter_n.sv | 31 +++
 rtl/array_stream_arbiter.sv | 140 ++++++++++++++
 tb/tb_array_stream_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/array_stream_arbiter_pkg.sv
// Shared definitions for the array stream write-port arbiter: state encoding,
// default burst geometry and a small index helper.
package array_stream_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    localparam int LANES           = 16;
    localparam int DEFAULT_BURST   = LANES;
    localparam int DEFAULT_TIMEOUT = 1023;

    function automatic int nextIndex(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/array_stream_arbiter_if.sv
// Requester and stream-top signals of the arbiter. The master modport is the
// arbiter itself; the slave modport is the surrounding producers and stream top.
interface array_stream_arbiter_if #(
    parameter int W = 32,
    parameter int N = 4
);
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   gnt;
    logic [N-1:0]   pop;
    logic [N-1:0]   done;
    logic           we;
    logic [W-1:0]   datain;
    logic           master_full;
    logic           master_empty;
    logic           valid;
    logic           busy;
    logic           err;

    modport master (
        input  req, req_data, master_full, master_empty, valid,
        output gnt, pop, done, we, datain, busy, err
    );

    modport slave (
        output req, req_data, master_full, master_empty, valid,
        input  gnt, pop, done, we, datain, busy, err
    );
endinterface

// File: rtl/array_stream_arbiter_rr_arbiter_n.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping around, returned both one-hot and encoded.
module rr_arbiter_n #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr_i) + k) % N);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/array_stream_arbiter.sv
// Shares the array stream write port between N requesters, one BURST-word grant
// at a time, and holds each grant until the serializer has drained the burst.
module array_stream_arbiter
    import array_stream_arbiter_pkg::*;
#(
    parameter int W       = 32,
    parameter int N       = 4,
    parameter int BURST   = DEFAULT_BURST,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic resetn,
    array_stream_arbiter_if.master bus
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(BURST + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    arb_state_e    state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] wordCnt_q, wordCnt_d;
    logic [CW-1:0] validCnt_q, validCnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;
    logic [W-1:0]  data_q, data_d;

    logic [N-1:0]  pickGnt;
    logic [IW-1:0] pickIdx;
    logic          pickAny;
    logic          weInt;
    logic          drainDone;
    logic          drainTimeout;
    logic [W-1:0]  grantWord;

    rr_arbiter_n #(.N(N)) uPick (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .gnt_o (pickGnt),
        .idx_o (pickIdx),
        .any_o (pickAny)
    );

    assign grantWord = bus.req_data[int'(idx_q)*W +: W];
    assign bus.gnt   = gnt_q;
    assign bus.busy  = (state_q != IDLE);
    assign bus.err   = err_q;

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        idx_d        = idx_q;
        ptr_d        = ptr_q;
        wordCnt_d    = wordCnt_q;
        validCnt_d   = validCnt_q;
        timer_d      = timer_q;
        err_d        = err_q;
        data_d       = data_q;
        weInt        = 1'b0;
        drainDone    = 1'b0;
        drainTimeout = 1'b0;
        bus.we       = 1'b0;
        bus.pop      = '0;
        bus.done     = '0;
        bus.datain   = data_q;

        // The serializer may start emitting before the burst is fully written.
        if (state_q != IDLE && bus.valid && validCnt_q < CW'(BURST)) begin
            validCnt_d = validCnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (pickAny) begin
                    gnt_d      = pickGnt;
                    idx_d      = pickIdx;
                    wordCnt_d  = '0;
                    validCnt_d = '0;
                    timer_d    = '0;
                    state_d    = XFER;
                end
            end
            XFER: begin
                weInt      = !bus.master_full;
                bus.we     = weInt;
                bus.datain = grantWord;
                bus.pop    = gnt_q & {N{weInt}};
                if (weInt) begin
                    data_d    = grantWord;
                    wordCnt_d = wordCnt_q + 1'b1;
                    if (wordCnt_q == CW'(BURST - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (timer_q != TW'(TIMEOUT)) begin
                    timer_d = timer_q + 1'b1;
                end
                drainDone    = (validCnt_q >= CW'(BURST)) && bus.master_empty;
                drainTimeout = !drainDone && (timer_q == TW'(TIMEOUT));
                if (drainDone || drainTimeout) begin
                    bus.done = gnt_q;
                    gnt_d    = '0;
                    ptr_d    = IW'(nextIndex(int'(idx_q), N));
                    err_d    = err_q | drainTimeout;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            idx_q      <= '0;
            ptr_q      <= '0;
            wordCnt_q  <= '0;
            validCnt_q <= '0;
            timer_q    <= '0;
            err_q      <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            wordCnt_q  <= wordCnt_d;
            validCnt_q <= validCnt_d;
            timer_q    <= timer_d;
            err_q      <= err_d;
            data_q     <= data_d;
        end
    end

endmodule

// File: tb/tb_array_stream_arbiter.sv
// Bench for array_stream_arbiter: a grant table from reset, then multi-cycle
// burst sequences checked against a scoreboard of expected written words.
module tb_array_stream_arbiter;

    localparam int W       = 32;
    localparam int N       = 4;
    localparam int BURST   = 16;
    localparam int TIMEOUT = 1023;

    typedef struct {
        logic [N-1:0] req;
        logic         mf;
        logic [N-1:0] expGnt;
        logic         expBusy;
        logic         expWe;
        logic [N-1:0] expPop;
    } vec_t;

    typedef struct {
        logic [W-1:0] data;
        logic [N-1:0] gnt;
    } sb_t;

    logic clk;
    logic resetn;
    array_stream_arbiter_if #(.W(W), .N(N)) bus ();

    array_stream_arbiter #(.W(W), .N(N), .BURST(BURST), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int           vecCount = 0;
    int           missCount = 0;
    int           wrCount = 0;
    int           doneCount = 0;
    int           validTarget = 0;
    int           validSent = 0;
    logic         sbEnable = 1'b0;
    sb_t          sbQ[$];
    logic [N-1:0] doneLog[$];
    int           expSeq[N];
    logic [15:0]  reqSeq[N];
    logic [N*W-1:0] reqWords;
    vec_t         vecs[7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] wordOf(input int i, input int s);
        return W'(32'hC0DE_0000 + i*4096 + s);
    endfunction

    // Show-ahead requesters: each advances to its next word on its pop.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N; i++) reqSeq[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) if (bus.pop[i]) reqSeq[i] <= reqSeq[i] + 1'b1;
        end
    end

    always_comb begin
        reqWords = '0;
        for (int i = 0; i < N; i++) reqWords[i*W +: W] = wordOf(i, int'(reqSeq[i]));
    end
    assign bus.req_data = reqWords;

    initial begin
        bus.valid = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (validSent < validTarget) begin
                bus.valid = 1'b1;
                validSent++;
            end else begin
                bus.valid = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && sbEnable) begin
            if (bus.we) begin
                wrCount++;
                if (sbQ.size() == 0) begin
                    vecCount++;
                    missCount++;
                    $display("[TB] FAIL unexpectedWrite: got datain %0h, required no write", bus.datain);
                end else begin
                    sb_t e;
                    e = sbQ.pop_front();
                    checkOutput("datain", bus.datain, e.data);
                    checkOutput("gntOnWrite", bus.gnt, e.gnt);
                    checkOutput("popOnWrite", bus.pop, e.gnt);
                end
            end else begin
                checkOutput("popNoWrite", bus.pop, '0);
            end
            if (bus.done != '0) begin
                doneCount++;
                doneLog.push_back(bus.done);
            end
        end
    end

    task automatic pushBurst(input int i);
        for (int k = 0; k < BURST; k++) begin
            sb_t e;
            e.data = wordOf(i, expSeq[i]);
            e.gnt  = N'(1 << i);
            sbQ.push_back(e);
            expSeq[i]++;
        end
    endtask

    task automatic applyReset();
        resetn = 1'b0;
        bus.req = '0;
        bus.master_full = 1'b0;
        bus.master_empty = 1'b1;
        validTarget = validSent;
        sbQ.delete();
        doneLog.delete();
        for (int i = 0; i < N; i++) expSeq[i] = 0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic waitWrites(input int target, input int budget, input string name);
        int cyc = 0;
        while (cyc < budget && wrCount < target) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (wrCount < target) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL %s: got %0d writes, required %0d", name, wrCount, target);
        end
    endtask

    task automatic waitDone(input int target, input int budget, input string name, output int cycles);
        cycles = 0;
        while (cycles < budget && doneCount < target) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (doneCount < target) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL %s: got %0d done pulses, required %0d", name, doneCount, target);
        end
    endtask

    task automatic checkDone(input string name, input logic [N-1:0] expected);
        logic [N-1:0] got;
        got = '0;
        if (doneLog.size() != 0) got = doneLog.pop_front();
        checkOutput(name, got, expected);
    endtask

    // One full burst for an already-requesting grantee, drained with BURST valids.
    task automatic runBurst(input int grantee, input logic dropReq, input string name);
        int base;
        int dBase;
        int cyc;
        base  = wrCount;
        dBase = doneCount;
        waitWrites(base + BURST, 200, name);
        if (dropReq) bus.req = '0;
        validTarget = validSent + BURST;
        waitDone(dBase + 1, 200, name, cyc);
        checkDone({name, "Done"}, N'(1 << grantee));
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        applyReset();
        bus.master_full = v.mf;
        bus.req = v.req;
        @(posedge clk);
        #1;
        checkOutput($sformatf("vec%0dGnt", idx), bus.gnt, v.expGnt);
        checkOutput($sformatf("vec%0dBusy", idx), bus.busy, v.expBusy);
        checkOutput($sformatf("vec%0dWe", idx), bus.we, v.expWe);
        checkOutput($sformatf("vec%0dPop", idx), bus.pop, v.expPop);
    endtask

    initial begin
        int base;
        int dBase;
        int cyc;

        vecs[0] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000};
        vecs[1] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 4'b0001};
        vecs[2] = '{4'b1011, 1'b0, 4'b0001, 1'b1, 1'b1, 4'b0001};
        vecs[3] = '{4'b1010, 1'b0, 4'b0010, 1'b1, 1'b1, 4'b0010};
        vecs[4] = '{4'b1100, 1'b0, 4'b0100, 1'b1, 1'b1, 4'b0100};
        vecs[5] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 1'b0, 4'b0000};
        vecs[6] = '{4'b0110, 1'b1, 4'b0010, 1'b1, 1'b0, 4'b0000};

        resetn = 1'b0;
        bus.req = '0;
        bus.master_full = 1'b0;
        bus.master_empty = 1'b1;
        #3;
        checkOutput("rstGnt", bus.gnt, '0);
        checkOutput("rstPop", bus.pop, '0);
        checkOutput("rstDone", bus.done, '0);
        checkOutput("rstWe", bus.we, 1'b0);
        checkOutput("rstBusy", bus.busy, 1'b0);
        checkOutput("rstErr", bus.err, 1'b0);

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

        sbEnable = 1'b1;

        // Single requester, then pointer has moved past requester 0.
        applyReset();
        pushBurst(0);
        bus.req = 4'b0001;
        runBurst(0, 1'b1, "single");
        checkOutput("singleIdleBusy", bus.busy, 1'b0);
        checkOutput("singleIdleGnt", bus.gnt, '0);
        pushBurst(1);
        bus.req = 4'b0011;
        runBurst(1, 1'b1, "ptrAdvance");
        checkOutput("ptrAdvanceQueue", sbQ.size(), 0);

        // Three simultaneous requesters held across three bursts.
        applyReset();
        pushBurst(0);
        pushBurst(1);
        pushBurst(3);
        bus.req = 4'b1011;
        runBurst(0, 1'b0, "rrFirst");
        runBurst(1, 1'b0, "rrSecond");
        runBurst(3, 1'b1, "rrThird");
        checkOutput("rrQueue", sbQ.size(), 0);

        // Backpressure after word 7.
        applyReset();
        pushBurst(0);
        bus.req = 4'b0001;
        base = wrCount;
        dBase = doneCount;
        waitWrites(base + 7, 50, "stallPre");
        bus.master_full = 1'b1;
        for (int s = 0; s < 5; s++) begin
            #1;
            checkOutput($sformatf("stallWe%0d", s), bus.we, 1'b0);
            checkOutput($sformatf("stallPop%0d", s), bus.pop, '0);
            @(posedge clk);
            #1;
        end
        bus.master_full = 1'b0;
        waitWrites(base + BURST, 50, "stallPost");
        bus.req = '0;
        validTarget = validSent + BURST;
        waitDone(dBase + 1, 200, "stall", cyc);
        checkDone("stallDone", 4'b0001);
        checkOutput("stallWrites", wrCount - base, BURST);

        // Drain timeout with only 10 valids; err is sticky and service continues.
        applyReset();
        pushBurst(0);
        bus.req = 4'b0001;
        base = wrCount;
        dBase = doneCount;
        waitWrites(base + BURST, 50, "toWrites");
        bus.req = '0;
        checkOutput("toErrBefore", bus.err, 1'b0);
        validTarget = validSent + 10;
        waitDone(dBase + 1, TIMEOUT + 100, "toDone", cyc);
        checkOutput("toCycles", cyc, TIMEOUT + 1);
        checkDone("toDoneGnt", 4'b0001);
        checkOutput("toErrAfter", bus.err, 1'b1);
        pushBurst(1);
        bus.req = 4'b0010;
        runBurst(1, 1'b1, "toNext");
        checkOutput("toErrSticky", bus.err, 1'b1);

        // Reset in the middle of a burst.
        applyReset();
        pushBurst(0);
        bus.req = 4'b0001;
        base = wrCount;
        dBase = doneCount;
        waitWrites(base + 6, 50, "rstMidPre");
        #1 resetn = 1'b0;
        #1;
        checkOutput("rstMidWe", bus.we, 1'b0);
        checkOutput("rstMidGnt", bus.gnt, '0);
        checkOutput("rstMidBusy", bus.busy, 1'b0);
        checkOutput("rstMidQueue", sbQ.size(), BURST - 6);
        applyReset();
        checkOutput("rstMidNoDone", doneCount, dBase);
        pushBurst(1);
        bus.req = 4'b0010;
        runBurst(1, 1'b1, "rstMidFresh");

        // Valid pulses that start during XFER count toward the drain.
        applyReset();
        bus.master_empty = 1'b0;
        pushBurst(0);
        bus.req = 4'b0001;
        base = wrCount;
        dBase = doneCount;
        waitWrites(base + 4, 50, "earlyPre");
        validTarget = validSent + BURST;
        waitWrites(base + BURST, 50, "earlyWrites");
        bus.req = '0;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("earlyHeld", bus.busy, 1'b1);
        bus.master_empty = 1'b1;
        waitDone(dBase + 1, 5, "earlyDone", cyc);
        checkOutput("earlyCycles", cyc, 1);
        checkDone("earlyDoneGnt", 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

    initial begin
        #500_000;
        missCount++;
        $display("[TB] FAIL watchdog: got no completion, required finish before 500us");
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
